// File: rtl/shared_bus_controller.sv
// Bridges L2 miss/eviction requests onto the shared system bus: arbitration, address
// phase, snoop collection, line transfer and a valid/ready response back to L2.
module shared_bus_controller #(
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_SIZE     = 512,
    parameter int BYTE_SELECT   = 6,
    parameter int SNOOP_LATENCY = 2,
    parameter int DATA_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [1:0]            reqOp,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [LINE_SIZE-1:0]  reqData,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [LINE_SIZE-1:0]  respData,
    output logic [1:0]            respSnoop,
    output logic                  respError,
    output logic                  busReq,
    input  logic                  busGnt,
    output logic [7:0]            busOp,
    output logic [ADDR_WIDTH-1:0] busAddr,
    output logic [LINE_SIZE-1:0]  busDataOut,
    output logic                  busDataOE,
    input  logic [LINE_SIZE-1:0]  busDataIn,
    input  logic                  busDataValid,
    input  logic [1:0]            snoopIn
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_ADDR, S_SNOOP, S_WRDATA, S_DATA, S_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RFO = 2'd2, OP_INV = 2'd3
    } op_e;

    localparam int SW = $clog2(SNOOP_LATENCY + 1);
    localparam int TW = $clog2(DATA_TIMEOUT + 1);
    localparam logic [SW-1:0] SNOOP_LOAD = SW'(SNOOP_LATENCY);
    localparam logic [TW-1:0] TMO_LAST   = TW'(DATA_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << BYTE_SELECT) - ADDR_WIDTH'(1));

    function automatic logic [7:0] bus_code(input op_e op);
        case (op)
            OP_READ:  return 8'h52;
            OP_WRITE: return 8'h57;
            OP_RFO:   return 8'h4D;
            default:  return 8'h49;
        endcase
    endfunction

    // Reserved encoding 2'b11 is reported to L2 as a clean miss.
    function automatic logic [1:0] snoop_decode(input logic [1:0] s);
        return (s == 2'b11) ? 2'b00 : s;
    endfunction

    state_e                  state_q;
    op_e                     op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LINE_SIZE-1:0]    data_q;
    logic [1:0]              snoop_q;
    logic [SW-1:0]           snoop_cnt_q;
    logic [TW-1:0]           tmo_cnt_q;
    logic                    req_ready_q;
    logic                    bus_req_q;
    logic [7:0]              bus_op_q;
    logic [ADDR_WIDTH-1:0]   bus_addr_q;
    logic [LINE_SIZE-1:0]    bus_data_out_q;
    logic                    bus_data_oe_q;
    logic                    resp_valid_q;
    logic [LINE_SIZE-1:0]    resp_data_q;
    logic [1:0]              resp_snoop_q;
    logic                    resp_error_q;

    // NOTE: every output is a flop set on the transition into the state that owns it,
    // so the bus and L2 never see decode glitches; state and outputs use <= together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= OP_READ;
            addr_q         <= '0;
            // NOTE: the latched line is cleared too, so an aborted write can never leak
            // stale data onto the bus after reset.
            data_q         <= '0;
            snoop_q        <= 2'b00;
            snoop_cnt_q    <= '0;
            tmo_cnt_q      <= '0;
            req_ready_q    <= 1'b1;
            bus_req_q      <= 1'b0;
            bus_op_q       <= 8'h00;
            bus_addr_q     <= '0;
            bus_data_out_q <= '0;
            bus_data_oe_q  <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_snoop_q   <= 2'b00;
            resp_error_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (reqValid && req_ready_q) begin
                    op_q        <= op_e'(reqOp);
                    addr_q      <= reqAddr & LINE_MASK;
                    data_q      <= reqData;
                    req_ready_q <= 1'b0;
                    bus_req_q   <= 1'b1;
                    state_q     <= S_ARB;
                end
                S_ARB: if (busGnt) begin
                    bus_op_q   <= bus_code(op_q);
                    bus_addr_q <= addr_q;
                    state_q    <= S_ADDR;
                end
                S_ADDR: begin
                    bus_op_q    <= 8'h00;
                    bus_addr_q  <= '0;
                    snoop_cnt_q <= SNOOP_LOAD;
                    state_q     <= S_SNOOP;
                end
                S_SNOOP: begin
                    snoop_cnt_q <= snoop_cnt_q - SW'(1);
                    if (snoop_cnt_q == SW'(1)) begin
                        snoop_q <= snoop_decode(snoopIn);
                        case (op_q)
                            OP_WRITE: begin
                                bus_data_out_q <= data_q;
                                bus_data_oe_q  <= 1'b1;
                                state_q        <= S_WRDATA;
                            end
                            OP_INV: begin
                                bus_req_q    <= 1'b0;
                                resp_valid_q <= 1'b1;
                                resp_data_q  <= '0;
                                resp_snoop_q <= snoop_decode(snoopIn);
                                resp_error_q <= 1'b0;
                                state_q      <= S_RESP;
                            end
                            default: begin
                                tmo_cnt_q <= '0;
                                state_q   <= S_DATA;
                            end
                        endcase
                    end
                end
                S_WRDATA: begin
                    bus_data_out_q <= '0;
                    bus_data_oe_q  <= 1'b0;
                    bus_req_q      <= 1'b0;
                    resp_valid_q   <= 1'b1;
                    resp_data_q    <= '0;
                    resp_snoop_q   <= snoop_q;
                    resp_error_q   <= 1'b0;
                    state_q        <= S_RESP;
                end
                S_DATA: begin
                    // Data arriving on the final allowed cycle still beats the timeout.
                    if (busDataValid || tmo_cnt_q == TMO_LAST) begin
                        bus_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= busDataValid ? busDataIn : '0;
                        resp_snoop_q <= snoop_q;
                        resp_error_q <= !busDataValid;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                S_RESP: if (respReady) begin
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= '0;
                    resp_snoop_q <= 2'b00;
                    resp_error_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reqReady   = req_ready_q;
    assign respValid  = resp_valid_q;
    assign respData   = resp_data_q;
    assign respSnoop  = resp_snoop_q;
    assign respError  = resp_error_q;
    assign busReq     = bus_req_q;
    assign busOp      = bus_op_q;
    assign busAddr    = bus_addr_q;
    assign busDataOut = bus_data_out_q;
    assign busDataOE  = bus_data_oe_q;

endmodule

// File: tb/tb_shared_bus_controller.sv
// Directed bench for shared_bus_controller: one task per scenario, inline comparisons
// against hand-computed values, DATA_TIMEOUT reduced to 8.
module tb_shared_bus_controller;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         reqValid = 1'b0;
    logic         reqReady;
    logic [1:0]   reqOp = 2'd0;
    logic [31:0]  reqAddr = '0;
    logic [511:0] reqData = '0;
    logic         respValid;
    logic         respReady = 1'b0;
    logic [511:0] respData;
    logic [1:0]   respSnoop;
    logic         respError;
    logic         busReq;
    logic         busGnt = 1'b0;
    logic [7:0]   busOp;
    logic [31:0]  busAddr;
    logic [511:0] busDataOut;
    logic         busDataOE;
    logic [511:0] busDataIn = '0;
    logic         busDataValid = 1'b0;
    logic [1:0]   snoopIn = 2'b00;

    int n_cmp = 0;
    int n_err = 0;

    // Bus activity monitor (only this process writes these).
    int           op_cnt = 0;
    int           oe_cnt = 0;
    logic [7:0]   mon_op = 8'h00;
    logic [31:0]  mon_addr = '0;
    logic [511:0] mon_wdata = '0;

    localparam logic [511:0] D55 = {64{8'h55}};

    shared_bus_controller #(
        .ADDR_WIDTH(32), .LINE_SIZE(512), .BYTE_SELECT(6),
        .SNOOP_LATENCY(2), .DATA_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
        .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respReady(respReady), .respData(respData),
        .respSnoop(respSnoop), .respError(respError),
        .busReq(busReq), .busGnt(busGnt), .busOp(busOp), .busAddr(busAddr),
        .busDataOut(busDataOut), .busDataOE(busDataOE),
        .busDataIn(busDataIn), .busDataValid(busDataValid), .snoopIn(snoopIn)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busOp != 8'h00) begin
            op_cnt++;
            mon_op = busOp;
            mon_addr = busAddr;
        end
        if (busDataOE) begin
            oe_cnt++;
            mon_wdata = busDataOut;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [31:0] addr,
                            input logic [511:0] data);
        reqValid = 1'b1; reqOp = op; reqAddr = addr; reqData = data;
        tick();
        reqValid = 1'b0; reqOp = 2'd0; reqAddr = '0; reqData = '0;
    endtask

    task automatic wait_resp(input int max_cyc, output int cyc);
        cyc = 0;
        while (respValid !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        if (respValid !== 1'b1) cyc = -1;
    endtask

    task automatic handshake();
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL reset_reqReady got=%b exp=1", reqReady); end
        n_cmp++; if ({busReq, busOp, busDataOE, respValid, respError, respSnoop} !== 14'd0) begin n_err++; $display("FAIL reset_ctrl got req=%b op=%h oe=%b rv=%b err=%b snp=%b exp all 0", busReq, busOp, busDataOE, respValid, respError, respSnoop); end
        n_cmp++; if ({busAddr, busDataOut, respData} !== '0) begin n_err++; $display("FAIL reset_data busAddr=%h busDataOut/respData nonzero exp 0", busAddr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        busGnt = 1'b1; snoopIn = 2'b00;
        send_req(2'd0, 32'h1234_5678, '0);
        n_cmp++; if ({busReq, reqReady, busOp} !== {1'b1, 1'b0, 8'h00}) begin n_err++; $display("FAIL rd_arb got req=%b rdy=%b op=%h exp 1 0 00", busReq, reqReady, busOp); end
        tick();
        n_cmp++; if (busOp !== 8'h52) begin n_err++; $display("FAIL rd_busop got=%h exp=52", busOp); end
        n_cmp++; if (busAddr !== 32'h1234_5640) begin n_err++; $display("FAIL rd_busaddr got=%h exp=12345640", busAddr); end
        tick();
        n_cmp++; if ({busOp, busAddr} !== 40'd0) begin n_err++; $display("FAIL rd_addr_1cyc got op=%h addr=%h exp 0", busOp, busAddr); end
        busDataValid = 1'b1; busDataIn = 512'hDEAD;
        tick();
        tick();
        busDataValid = 1'b0; busDataIn = '0;
        repeat (3) tick();
        n_cmp++; if (respValid !== 1'b0) begin n_err++; $display("FAIL rd_early_resp got=%b exp=0", respValid); end
        busDataValid = 1'b1; busDataIn = 512'hABCD;
        tick();
        busDataValid = 1'b0; busDataIn = '0;
        n_cmp++; if (respValid !== 1'b1) begin n_err++; $display("FAIL rd_respvalid got=%b exp=1", respValid); end
        n_cmp++; if (respData !== 512'hABCD) begin n_err++; $display("FAIL rd_respdata got=%h exp=abcd", respData); end
        n_cmp++; if ({respSnoop, respError, busReq} !== 4'b0000) begin n_err++; $display("FAIL rd_resp_flags got snp=%b err=%b req=%b exp 00 0 0", respSnoop, respError, busReq); end
        handshake();
        n_cmp++; if ({respValid, reqReady} !== 2'b01) begin n_err++; $display("FAIL rd_done got rv=%b rdy=%b exp 0 1", respValid, reqReady); end
    endtask

    task automatic test_write();
        int o0, e0, cyc;
        o0 = op_cnt; e0 = oe_cnt;
        busGnt = 1'b1; snoopIn = 2'b10;
        send_req(2'd1, 32'h0000_0040, D55);
        wait_resp(20, cyc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL wr_latency got=%0d exp=5", cyc); end
        n_cmp++; if ({mon_op, mon_addr} !== {8'h57, 32'h40}) begin n_err++; $display("FAIL wr_busop got op=%h addr=%h exp 57 00000040", mon_op, mon_addr); end
        n_cmp++; if (op_cnt - o0 !== 1) begin n_err++; $display("FAIL wr_addr_cycles got=%0d exp=1", op_cnt - o0); end
        n_cmp++; if (oe_cnt - e0 !== 1) begin n_err++; $display("FAIL wr_oe_cycles got=%0d exp=1", oe_cnt - e0); end
        n_cmp++; if (mon_wdata !== D55) begin n_err++; $display("FAIL wr_data got=%h exp=%h", mon_wdata, D55); end
        n_cmp++; if ({respSnoop, respError} !== 3'b100) begin n_err++; $display("FAIL wr_snoop got snp=%b err=%b exp 10 0", respSnoop, respError); end
        n_cmp++; if (respData !== '0) begin n_err++; $display("FAIL wr_respdata got=%h exp=0", respData); end
        handshake();
    endtask

    task automatic arb_wait4(input string name);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({busReq, busOp} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL %s_arb%0d got req=%b op=%h exp 1 00", name, i, busReq, busOp); end
            if (i == 3) busGnt = 1'b1;
            tick();
        end
        busGnt = 1'b0;
    endtask

    task automatic test_back_to_back();
        int e0, cyc;
        e0 = oe_cnt;
        busGnt = 1'b0; snoopIn = 2'b01;
        busDataValid = 1'b1; busDataIn = 512'hF00D_CAFE;
        send_req(2'd2, 32'h1000_0FFF, '0);
        arb_wait4("rfo");
        n_cmp++; if ({busOp, busAddr} !== {8'h4D, 32'h1000_0FC0}) begin n_err++; $display("FAIL rfo_addr got op=%h addr=%h exp 4d 10000fc0", busOp, busAddr); end
        wait_resp(20, cyc);
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL rfo_latency got=%0d exp=4", cyc); end
        n_cmp++; if ({respData, respSnoop} !== {512'hF00D_CAFE, 2'b01}) begin n_err++; $display("FAIL rfo_resp got data=%h snp=%b exp f00dcafe 01", respData, respSnoop); end
        handshake();
        n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", reqReady); end
        snoopIn = 2'b11;
        send_req(2'd3, 32'h2000_0001, '0);
        arb_wait4("inv");
        n_cmp++; if ({busOp, busAddr} !== {8'h49, 32'h2000_0000}) begin n_err++; $display("FAIL inv_addr got op=%h addr=%h exp 49 20000000", busOp, busAddr); end
        wait_resp(20, cyc);
        n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL inv_latency got=%0d exp=3", cyc); end
        n_cmp++; if ({respData, respSnoop, respError} !== '0) begin n_err++; $display("FAIL inv_resp got data=%h snp=%b err=%b exp 0", respData, respSnoop, respError); end
        n_cmp++; if (oe_cnt - e0 !== 0) begin n_err++; $display("FAIL inv_oe got=%0d exp=0", oe_cnt - e0); end
        handshake();
        busDataValid = 1'b0; busDataIn = '0;
    endtask

    task automatic test_timeout();
        int cyc;
        busGnt = 1'b1; snoopIn = 2'b00; busDataValid = 1'b0;
        send_req(2'd0, 32'h0000_0300, '0);
        tick();
        n_cmp++; if (busOp !== 8'h52) begin n_err++; $display("FAIL to_busop got=%h exp=52", busOp); end
        wait_resp(30, cyc);
        n_cmp++; if (cyc !== 11) begin n_err++; $display("FAIL to_latency got=%0d exp=11", cyc); end
        n_cmp++; if ({respError, respData} !== {1'b1, 512'd0}) begin n_err++; $display("FAIL to_error got err=%b data=%h exp 1 0", respError, respData); end
        handshake();
        // Data on the 8th DATA cycle must win over the timeout.
        send_req(2'd0, 32'h0000_0340, '0);
        tick();
        repeat (10) tick();
        n_cmp++; if (respValid !== 1'b0) begin n_err++; $display("FAIL to_edge_early got=%b exp=0", respValid); end
        busDataValid = 1'b1; busDataIn = 512'h7777;
        tick();
        busDataValid = 1'b0; busDataIn = '0;
        n_cmp++; if ({respValid, respError, respData} !== {1'b1, 1'b0, 512'h7777}) begin n_err++; $display("FAIL to_edge_wins got rv=%b err=%b data=%h exp 1 0 7777", respValid, respError, respData); end
        handshake();
        busDataValid = 1'b1; busDataIn = 512'h1357;
        send_req(2'd0, 32'h0000_0380, '0);
        tick();
        wait_resp(20, cyc);
        busDataValid = 1'b0; busDataIn = '0;
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL to_clean_latency got=%0d exp=4", cyc); end
        n_cmp++; if ({respError, respData} !== {1'b0, 512'h1357}) begin n_err++; $display("FAIL to_clean_resp got err=%b data=%h exp 0 1357", respError, respData); end
        handshake();
    endtask

    task automatic test_resp_backpressure();
        int cyc;
        busGnt = 1'b1; snoopIn = 2'b01;
        busDataValid = 1'b1; busDataIn = 512'hC5C5;
        send_req(2'd0, 32'h0000_0400, '0);
        wait_resp(20, cyc);
        busDataValid = 1'b0; busDataIn = '0;
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL bp_latency got=%0d exp=5", cyc); end
        reqValid = 1'b1; reqOp = 2'd1; reqAddr = 32'h0000_0500; reqData = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if ({respValid, respData, respSnoop, reqReady, busReq} !== {1'b1, 512'hC5C5, 2'b01, 1'b0, 1'b0}) begin n_err++; $display("FAIL bp_hold%0d got rv=%b data=%h snp=%b rdy=%b req=%b", i, respValid, respData, respSnoop, reqReady, busReq); end
        end
        respReady = 1'b1;
        tick();
        respReady = 1'b0;
        n_cmp++; if ({respValid, reqReady, busReq} !== 3'b010) begin n_err++; $display("FAIL bp_release got rv=%b rdy=%b req=%b exp 0 1 0", respValid, reqReady, busReq); end
        tick();
        reqValid = 1'b0; reqOp = 2'd0; reqAddr = '0;
        n_cmp++; if ({reqReady, busReq} !== 2'b01) begin n_err++; $display("FAIL bp_accept got rdy=%b req=%b exp 0 1", reqReady, busReq); end
        wait_resp(20, cyc);
        n_cmp++; if ({respSnoop, respData} !== {2'b01, 512'd0}) begin n_err++; $display("FAIL bp_write_resp got snp=%b data=%h exp 01 0", respSnoop, respData); end
        handshake();
    endtask

    task automatic test_reset_mid_data();
        busGnt = 1'b1; snoopIn = 2'b00; busDataValid = 1'b0;
        send_req(2'd0, 32'h0000_0600, '0);
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busOp, busReq, busDataOE, busAddr} !== '0) begin n_err++; $display("FAIL rst_bus got op=%h req=%b oe=%b addr=%h exp 0", busOp, busReq, busDataOE, busAddr); end
        n_cmp++; if ({respValid, respError, respSnoop, respData} !== '0) begin n_err++; $display("FAIL rst_resp got rv=%b err=%b snp=%b data=%h exp 0", respValid, respError, respSnoop, respData); end
        tick();
        tick();
        rst_n = 1'b1;
        busDataValid = 1'b1; busDataIn = 512'h9999;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if ({respValid, reqReady, busReq} !== 3'b010) begin n_err++; $display("FAIL rst_after%0d got rv=%b rdy=%b req=%b exp 0 1 0", i, respValid, reqReady, busReq); end
        end
        busDataValid = 1'b0; busDataIn = '0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_resp_backpressure();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (compared=%0d mismatched=%0d)", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
